// File: rtl/bserial_pkg.sv
// Shared definitions for the binary-serial MAC stage.
// Provides the controller state encoding, the default operand and
// partial-sum widths, and the bit-counter width derived from WIDTH.
package bserial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_ACC_WIDTH = 24;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int DEF_CNT_WIDTH = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/bserial_mac.sv
// Binary-serial multiply-accumulate stage of a systolic PE.
// Multiplies a parallel signed weight by a bit-serial (LSB first) signed
// activation, adds the partial sum from the PE above and emits the result.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   i_clr      synchronous clear, aborts the current product
//   i_start    first-bit strobe, samples i_weight and i_psum
//   i_ifm_bit  activation bit, LSB first
//   i_weight   signed weight (WIDTH)
//   i_psum     signed partial sum in (ACC_WIDTH)
//   o_ifm_bit  i_ifm_bit delayed one cycle for the right neighbour
//   o_start    i_start delayed one cycle for the right neighbour
//   o_psum     signed accumulated result, held until the next o_valid
//   o_valid    one-cycle pulse, o_psum is new
//   o_busy     high while a product is running
//   o_overrun  one-cycle pulse, an i_start was rejected
module bserial_mac
  import bserial_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_start,
  input  logic                 i_ifm_bit,
  input  logic [WIDTH-1:0]     i_weight,
  input  logic [ACC_WIDTH-1:0] i_psum,
  output logic                 o_ifm_bit,
  output logic                 o_start,
  output logic [ACC_WIDTH-1:0] o_psum,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_overrun
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t               state;
  logic [CNT_W-1:0]     k;
  logic [ACC_WIDTH-1:0] w;
  logic [ACC_WIDTH-1:0] acc;

  logic [ACC_WIDTH-1:0] weight_ext;
  logic [ACC_WIDTH-1:0] seed_add;
  logic [ACC_WIDTH-1:0] addend;
  logic                 last_bit;

  assign weight_ext = {{(ACC_WIDTH-WIDTH){i_weight[WIDTH-1]}}, i_weight};
  assign seed_add   = i_ifm_bit ? weight_ext : '0;
  assign addend     = i_ifm_bit ? (w << k) : '0;
  assign last_bit   = (k == CNT_W'(WIDTH-1));
  assign o_busy     = (state == RUN);

  // NOTE: every register here is updated with <= so that all flops sample
  // the same pre-edge values; the accumulator reads acc and w from the
  // previous cycle while updating both in the same block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      w         <= '0;
      acc       <= '0;
      o_ifm_bit <= 1'b0;
      o_start   <= 1'b0;
      o_psum    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      // Forwarding to the right neighbour is independent of i_clr.
      o_ifm_bit <= i_ifm_bit;
      o_start   <= i_start;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;

      if (i_clr) begin
        // o_psum and the weight latch are deliberately left untouched.
        state <= IDLE;
        acc   <= '0;
        k     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              w     <= weight_ext;
              acc   <= i_psum + seed_add;
              k     <= CNT_W'(1);
              state <= RUN;
            end
          end
          RUN: begin
            if (last_bit) begin
              // The sign bit carries weight -2^(WIDTH-1): subtract.
              o_psum  <= acc - addend;
              o_valid <= 1'b1;
              if (i_start) begin
                // Back-to-back: seed the next product in the same cycle.
                w   <= weight_ext;
                acc <= i_psum + seed_add;
                k   <= CNT_W'(1);
              end else begin
                k     <= '0;
                state <= IDLE;
              end
            end else begin
              acc <= acc + addend;
              k   <= k + CNT_W'(1);
              if (i_start) o_overrun <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bserial_mac.sv
module tb_bserial_mac;

  localparam int W  = 8;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_clr;
  logic          i_start;
  logic          i_ifm_bit;
  logic [W-1:0]  i_weight;
  logic [AW-1:0] i_psum;
  logic          o_ifm_bit;
  logic          o_start;
  logic [AW-1:0] o_psum;
  logic          o_valid;
  logic          o_busy;
  logic          o_overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] sb_q[$];
  logic          sb_en = 1'b1;
  logic          exp_ifm = 1'b0;
  logic          exp_start = 1'b0;
  logic [AW-1:0] last_psum = '0;

  bserial_mac #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (i_clr),
    .i_start   (i_start),
    .i_ifm_bit (i_ifm_bit),
    .i_weight  (i_weight),
    .i_psum    (i_psum),
    .o_ifm_bit (o_ifm_bit),
    .o_start   (o_start),
    .o_psum    (o_psum),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_overrun (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] model(input logic [W-1:0] w, input logic [W-1:0] x,
                                          input logic [AW-1:0] p);
    int a, b;
    a = int'($signed(w));
    b = int'($signed(x));
    return p + AW'(a * b);
  endfunction

  // Reference one-cycle delay for the forwarding outputs.
  always @(posedge clk) begin
    if (rst) begin
      exp_ifm   <= 1'b0;
      exp_start <= 1'b0;
    end else begin
      exp_ifm   <= i_ifm_bit;
      exp_start <= i_start;
    end
  end

  // Output monitor: forwarding every cycle, results against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      check("fwd_ifm", 32'(o_ifm_bit), 32'(exp_ifm));
      check("fwd_start", 32'(o_start), 32'(exp_start));
      if (sb_en && o_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 32'(o_valid), 32'd0);
        end else begin
          last_psum = sb_q.pop_front();
          check("psum", 32'(o_psum), 32'(last_psum));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic b, input logic [W-1:0] w,
                       input logic [AW-1:0] p, input logic clr = 1'b0);
    i_start   = st;
    i_ifm_bit = b;
    i_weight  = w;
    i_psum    = p;
    i_clr     = clr;
    step();
  endtask

  // Drive activation bits first..last; bit 0 carries the start strobe.
  // Weight and psum are randomised outside the start cycle to prove they
  // are only sampled at i_start.
  task automatic mac(input logic [W-1:0] w, input logic [W-1:0] x, input logic [AW-1:0] p,
                     input int first, input int last, input logic push = 1'b1);
    for (int i = first; i <= last; i++) begin
      if (i == 0 && push) sb_q.push_back(model(w, x, p));
      drive(i == 0, x[i], (i == 0) ? w : W'($urandom), (i == 0) ? p : AW'($urandom));
      if (i < W-1) check("busy_run", 32'(o_busy), 32'd1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    i_clr = 1'b0; i_start = 1'b0; i_ifm_bit = 1'b0; i_weight = '0; i_psum = '0;
    step(); step(); step();
    check("rst_psum", 32'(o_psum), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    idle(1);

    // Basic product with latency and busy checks.
    mac(8'd3, 8'd5, 24'd10, 0, 7);
    check("valid_lat", 32'(o_valid), 32'd1);
    check("busy_done", 32'(o_busy), 32'd0);
    check("psum_25", 32'(o_psum), 32'd25);
    idle(1);
    check("valid_pulse", 32'(o_valid), 32'd0);
    check("psum_hold", 32'(o_psum), 32'd25);

    // Extremes and the sign-bit subtraction path.
    mac(8'h80, 8'h80, 24'd0, 0, 7);
    check("psum_16384", 32'(o_psum), 32'd16384);
    idle(2);
    mac(8'd127, 8'hFF, 24'hFFFFFF, 0, 7);
    check("psum_m128", 32'(o_psum), 32'h00FF_FF80);
    idle(2);

    // Back-to-back: the shared cycle's bit is A's sign bit and B's bit 0.
    mac(8'd2, 8'd3, 24'd0, 0, W-2);
    mac(8'hFF, 8'd4, 24'd100, 0, 7);
    check("b2b_psum", 32'(o_psum), 32'd96);
    mac(8'hF9, 8'hFD, 24'd7, 0, W-2);
    mac(8'd11, 8'h05, 24'hFFFFF0, 0, 7);
    idle(2);

    // Rejected start mid-product.
    mac(8'd9, 8'hA5, 24'd1000, 0, 2);
    drive(1'b1, 1'b0, 8'h7F, 24'h123456);
    check("overrun", 32'(o_overrun), 32'd1);
    mac(8'd9, 8'hA5, 24'd1000, 4, 7);
    check("overrun_pulse", 32'(o_overrun), 32'd0);
    check("overrun_result", 32'(o_psum), 32'(model(8'd9, 8'hA5, 24'd1000)));
    idle(2);

    // Clear at cycle 4, with a simultaneous start that must be ignored.
    mac(8'd5, 8'd7, 24'd3, 0, 3, 1'b0);
    drive(1'b1, 1'b1, 8'd1, 24'd1, 1'b1);
    check("clr_busy", 32'(o_busy), 32'd0);
    check("clr_overrun", 32'(o_overrun), 32'd0);
    check("clr_psum_kept", 32'(o_psum), 32'(last_psum));
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, '0, '0);
      check("clr_no_valid", 32'(o_valid), 32'd0);
    end

    // Reset mid-product.
    mac(8'd5, 8'd7, 24'd3, 0, 3, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'd1, 24'd1);
    check("rst_mid_psum", 32'(o_psum), 32'd0);
    check("rst_mid_busy", 32'(o_busy), 32'd0);
    check("rst_mid_fwd", 32'({o_ifm_bit, o_start, o_valid, o_overrun}), 32'd0);
    rst = 1'b0;
    idle(2);

    // Random forwarding stream, including clears; results not scored here.
    sb_en = 1'b0;
    for (int i = 0; i < 80; i++)
      drive(1'($urandom), 1'($urandom), W'($urandom), AW'($urandom), ($urandom_range(0, 7) == 0));
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    sb_en = 1'b1;

    // Result after random traffic.
    mac(8'hC3, 8'h3C, 24'h000100, 0, 7);
    idle(2);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
